burst_ctrl: RTL and testbench

BURST_CTRL -- requirements
Module: burst_ctrl

---
 rtl/mod465_pkg.sv | 24 ++
 rtl/lfsr7.sv | 28 ++
 rtl/burst_ctrl.sv | 168 ++++++++++++++++
 tb/tb_burst_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod465_pkg.sv
// Shared types for the burst controller: FSM state encoding, symbol-select codes
// and the 7-bit preamble LFSR step (x^7+x^6+1).
package mod465_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_PAYLOAD  = 2'd2,
        ST_GUARD    = 2'd3
    } state_e;

    localparam logic [1:0] SYM_ZERO = 2'd0;
    localparam logic [1:0] SYM_PRE  = 2'd1;
    localparam logic [1:0] SYM_DATA = 2'd2;

    localparam int         CNT_W     = 9;
    localparam logic [6:0] LFSR_SEED = 7'h7F;

    // Fibonacci form: shift toward the MSB, feedback from taps 7 and 6.
    function automatic logic [6:0] lfsr7_next(input logic [6:0] cur);
        return {cur[5:0], cur[6] ^ cur[5]};
    endfunction

endpackage

// File: rtl/lfsr7.sv
// 7-bit preamble scrambler LFSR; reload to LFSR_SEED on load, advance on step.
// Instantiated by burst_ctrl only when BURST_CTRL_PREAMBLE_LFSR_EN is defined.
module lfsr7
    import mod465_pkg::*;
(
    input  logic       clk_in,
    input  logic       reset,
    input  logic       load,
    input  logic       step,
    output logic [6:0] q
);

    logic [6:0] lfsr_q;
    logic [6:0] lfsr_d;

    assign lfsr_d = load ? LFSR_SEED : (step ? lfsr7_next(lfsr_q) : lfsr_q);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/burst_ctrl.sv
// Burst framer: preamble, clamped payload, then zero-symbol guard, paced by the
// rising edge of sym_clk_ena. Define BURST_CTRL_PREAMBLE_LFSR_EN for an LFSR preamble.
module burst_ctrl
    import mod465_pkg::*;
#(
    parameter int PREAMBLE_LEN = 16,
    parameter int GUARD_LEN    = 4,
    parameter int MAX_PAYLOAD  = 256
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       sym_clk_ena,
    input  logic       start,
    input  logic [8:0] payload_len,
    input  logic       data_valid,
    output logic       data_ready,
    output logic [1:0] sym_sel,
    output logic       pre_bit,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    localparam logic [CNT_W-1:0] PRE_LEN_C   = CNT_W'(PREAMBLE_LEN);
    localparam logic [CNT_W-1:0] GUARD_LEN_C = CNT_W'(GUARD_LEN);
    localparam logic [CNT_W-1:0] MAX_LEN_C   = CNT_W'(MAX_PAYLOAD);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] len_q;
    logic             ena_q;
    logic             armed_q;
    logic             underrun_q;
    logic [1:0]       sym_sel_q;
    logic             pre_bit_q;
    logic             done_q;

    logic             tick;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] len_d;
    logic             first_pre_bit;
    logic             next_pre_bit;

    // One tick per enable pulse, however many clk_in cycles the enable stays high.
    assign tick    = sym_clk_ena & ~ena_q;
    assign cnt_inc = cnt_q + CNT_W'(1);
    assign len_d   = (payload_len > MAX_LEN_C) ? MAX_LEN_C : payload_len;

`ifdef BURST_CTRL_PREAMBLE_LFSR_EN
    logic       lfsr_load;
    logic       lfsr_step;
    logic [6:0] lfsr_val;

    assign lfsr_load = tick & armed_q & (state_q == ST_IDLE);
    assign lfsr_step = tick & (state_q == ST_PREAMBLE);

    lfsr7 u_lfsr7 (
        .clk_in (clk_in),
        .reset  (reset),
        .load   (lfsr_load),
        .step   (lfsr_step),
        .q      (lfsr_val)
    );

    // Bit 5 becomes the MSB after this tick's step, so it is the symbol's bit.
    assign first_pre_bit = LFSR_SEED[6];
    assign next_pre_bit  = lfsr_val[5];
`else
    assign first_pre_bit = 1'b1;
    assign next_pre_bit  = ~pre_bit_q;
`endif

    // NOTE: every register below uses non-blocking assignment so all updates
    // see the pre-edge values; blocking here would chain state within one edge.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            ena_q      <= 1'b0;
            armed_q    <= 1'b0;
            underrun_q <= 1'b0;
            sym_sel_q  <= SYM_ZERO;
            pre_bit_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            ena_q  <= sym_clk_ena;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (tick && armed_q) begin
                        // The arming tick already launches the first preamble symbol.
                        armed_q   <= 1'b0;
                        sym_sel_q <= SYM_PRE;
                        pre_bit_q <= first_pre_bit;
                        if (PRE_LEN_C == CNT_W'(1)) begin
                            cnt_q   <= '0;
                            state_q <= (len_q == '0) ? ST_GUARD : ST_PAYLOAD;
                        end else begin
                            cnt_q   <= CNT_W'(1);
                            state_q <= ST_PREAMBLE;
                        end
                    end else if (start) begin
                        len_q      <= len_d;
                        underrun_q <= 1'b0;
                        armed_q    <= 1'b1;
                    end
                end

                ST_PREAMBLE: begin
                    if (tick) begin
                        sym_sel_q <= SYM_PRE;
                        pre_bit_q <= next_pre_bit;
                        if (cnt_inc == PRE_LEN_C) begin
                            cnt_q   <= '0;
                            state_q <= (len_q == '0) ? ST_GUARD : ST_PAYLOAD;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                end

                ST_PAYLOAD: begin
                    if (tick) begin
                        pre_bit_q <= 1'b0;
                        // A starved slot is sent as a zero symbol; the burst keeps its length.
                        sym_sel_q <= data_valid ? SYM_DATA : SYM_ZERO;
                        if (!data_valid) begin
                            underrun_q <= 1'b1;
                        end
                        if (cnt_inc == len_q) begin
                            cnt_q   <= '0;
                            state_q <= ST_GUARD;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                end

                ST_GUARD: begin
                    if (tick) begin
                        sym_sel_q <= SYM_ZERO;
                        pre_bit_q <= 1'b0;
                        if (cnt_inc == GUARD_LEN_C) begin
                            cnt_q   <= '0;
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_ready = tick & (state_q == ST_PAYLOAD);
    assign sym_sel    = sym_sel_q;
    assign pre_bit    = pre_bit_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_burst_ctrl.sv
// Directed bench for burst_ctrl: symbol stream scoreboard plus burst-level checks.
// Golden preamble follows BURST_CTRL_PREAMBLE_LFSR_EN when defined.
module tb_burst_ctrl;

    localparam int PRE   = 16;
    localparam int GUARD = 4;
    localparam int MAXP  = 256;

    localparam logic [1:0] S_ZERO = 2'd0;
    localparam logic [1:0] S_PRE  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    typedef struct packed {
        logic [1:0] sym;
        logic       pre;
    } sym_t;

    logic       clk_in;
    logic       reset;
    logic       sym_clk_ena;
    logic       start;
    logic [8:0] payload_len;
    logic       data_valid;
    logic       data_ready;
    logic [1:0] sym_sel;
    logic       pre_bit;
    logic       busy;
    logic       done;
    logic       underrun;

    sym_t exp_q[$];

    int          checks     = 0;
    int          passes     = 0;
    int          fails      = 0;
    int unsigned cyc        = 0;
    int          tick_cnt   = 0;
    int          drop_tick  = -1;
    int          dr_cnt     = 0;
    int          done_cnt   = 0;
    int          done_tick  = 0;
    int          extra_cnt  = 0;
    int          burst_base = 0;
    int          exp_total  = 0;
    int          done_base  = 0;

    burst_ctrl dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .sym_clk_ena (sym_clk_ena),
        .start       (start),
        .payload_len (payload_len),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .sym_sel     (sym_sel),
        .pre_bit     (pre_bit),
        .busy        (busy),
        .done        (done),
        .underrun    (underrun)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic pre_gold(input int k);
`ifdef BURST_CTRL_PREAMBLE_LFSR_EN
        logic [6:0] s;
        s = 7'h7F;
        for (int i = 0; i < k; i++) s = {s[5:0], s[6] ^ s[5]};
        return s[6];
`else
        return (k % 2) == 0;
`endif
    endfunction

    // Symbol-rate enable: high for phases 0 and 1 of every 32 cycles; phase 0 is a tick.
    initial begin
        sym_clk_ena = 1'b0;
        data_valid  = 1'b1;
        forever begin
            @(negedge clk_in);
            cyc++;
            sym_clk_ena = (cyc % 32) < 2;
            if (cyc % 32 == 0) tick_cnt++;
            data_valid = !((cyc % 32 == 0) && (tick_cnt == drop_tick));
        end
    end

    // Output monitor: the cycle after each tick carries that tick's symbol.
    initial begin
        logic ena_prev;
        bit   tick_prev;
        bit   tick_now;
        sym_t e;
        ena_prev  = 1'b0;
        tick_prev = 1'b0;
        forever begin
            @(negedge clk_in);
            #3;
            tick_now = sym_clk_ena && !ena_prev;
            ena_prev = sym_clk_ena;
            if (data_ready) dr_cnt++;
            if (done) begin
                done_cnt++;
                done_tick = tick_cnt;
            end
            if (tick_prev && (busy || done)) begin
                if (exp_q.size() == 0) begin
                    extra_cnt++;
                end else begin
                    e = exp_q.pop_front();
                    check("sym_sel", 32'(sym_sel), 32'(e.sym));
                    if (e.sym == S_PRE) check("pre_bit", 32'(pre_bit), 32'(e.pre));
                end
            end
            tick_prev = tick_now;
        end
    end

    task automatic step_to_phase(input int unsigned ph);
        @(negedge clk_in);
        #1;
        while (cyc % 32 != ph) begin
            @(negedge clk_in);
            #1;
        end
    endtask

    task automatic launch(input int len, input bit coincide, input int drop_idx);
        sym_t e;
        int   eff;
        step_to_phase(coincide ? 0 : 8);
        eff        = (len > MAXP) ? MAXP : len;
        burst_base = tick_cnt + 1;
        exp_total  = PRE + eff + GUARD;
        drop_tick  = (drop_idx >= 0) ? (burst_base + PRE + drop_idx) : -1;
        dr_cnt     = 0;
        extra_cnt  = 0;
        done_base  = done_cnt;
        for (int i = 0; i < PRE; i++) begin
            e.sym = S_PRE;
            e.pre = pre_gold(i);
            exp_q.push_back(e);
        end
        for (int i = 0; i < eff; i++) begin
            e.sym = (i == drop_idx) ? S_ZERO : S_DATA;
            e.pre = 1'b0;
            exp_q.push_back(e);
        end
        for (int i = 0; i < GUARD; i++) begin
            e.sym = S_ZERO;
            e.pre = 1'b0;
            exp_q.push_back(e);
        end
        start       = 1'b1;
        payload_len = len[8:0];
        @(negedge clk_in);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_tick(input int t);
        int n;
        n = 0;
        while (tick_cnt < t && n < 20000) begin
            @(negedge clk_in);
            #1;
            n++;
        end
        check("tick_reached", 32'(tick_cnt >= t), 32'(1));
    endtask

    task automatic finish_burst(input string tag, input int exp_dr);
        int n;
        int budget;
        n      = 0;
        budget = (exp_total + 4) * 32;
        while (done_cnt == done_base && n < budget) begin
            @(negedge clk_in);
            #4;
            n++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt), 32'(done_base + 1));
        check({tag, "_duration"}, 32'(done_tick - burst_base + 1), 32'(exp_total));
        check({tag, "_data_ready"}, 32'(dr_cnt), 32'(exp_dr));
        check({tag, "_sym_left"}, 32'(exp_q.size()), 32'(0));
        check({tag, "_sym_extra"}, 32'(extra_cnt), 32'(0));
        check({tag, "_busy_after"}, 32'(busy), 32'(0));
        @(negedge clk_in);
        #4;
        check({tag, "_done_1cyc"}, 32'(done), 32'(0));
        exp_q.delete();
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        payload_len = '0;
        repeat (3) @(negedge clk_in);
        #1;
        check("rst_sym_sel", 32'(sym_sel), 32'(0));
        check("rst_pre_bit", 32'(pre_bit), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_data_ready", 32'(data_ready), 32'(0));
        check("rst_underrun", 32'(underrun), 32'(0));
        reset = 1'b0;

        // Nominal burst, 8 payload symbols.
        launch(8, 1'b0, -1);
        finish_burst("len8", 8);
        check("len8_underrun", 32'(underrun), 32'(0));

        // Third payload slot starved.
        launch(8, 1'b0, 2);
        finish_burst("starve", 8);
        check("starve_underrun", 32'(underrun), 32'(1));
        repeat (100) @(negedge clk_in);
        #1;
        check("starve_sticky", 32'(underrun), 32'(1));

        // Empty payload; the accepted start also clears underrun.
        launch(0, 1'b0, -1);
        check("len0_underrun_clr", 32'(underrun), 32'(0));
        finish_burst("len0", 0);

        // Start coincident with an IDLE tick, then a start during PAYLOAD that must be ignored.
        launch(4, 1'b1, -1);
        wait_tick(burst_base + PRE + 1);
        step_to_phase(8);
        check("mid_start_busy", 32'(busy), 32'(1));
        start       = 1'b1;
        payload_len = 9'd2;
        @(negedge clk_in);
        #1;
        start = 1'b0;
        finish_burst("coinc", 4);
        repeat (100) @(negedge clk_in);
        #4;
        check("ignored_start_busy", 32'(busy), 32'(0));
        check("ignored_start_extra", 32'(extra_cnt), 32'(0));

        // Reset in the middle of PAYLOAD.
        launch(8, 1'b0, -1);
        wait_tick(burst_base + PRE + 2);
        step_to_phase(6);
        check("pre_reset_busy", 32'(busy), 32'(1));
        reset = 1'b1;
        #1;
        check("mid_rst_sym_sel", 32'(sym_sel), 32'(0));
        check("mid_rst_pre_bit", 32'(pre_bit), 32'(0));
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_done", 32'(done), 32'(0));
        check("mid_rst_data_ready", 32'(data_ready), 32'(0));
        exp_q.delete();
        done_base = done_cnt;
        repeat (4) @(negedge clk_in);
        #1;
        reset = 1'b0;
        repeat (80) @(negedge clk_in);
        #4;
        check("abort_no_done", 32'(done_cnt), 32'(done_base));
        check("abort_idle", 32'(busy), 32'(0));
        check("abort_extra", 32'(extra_cnt), 32'(0));
        launch(3, 1'b0, -1);
        finish_burst("post_rst", 3);

        // Oversized request is clamped to MAX_PAYLOAD.
        launch(400, 1'b0, -1);
        finish_burst("clamp", MAXP);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
